fifo_serial_tx: RTL and testbench

Downstream drain stage for the 5-bit synchronous FIFO. It pops one word at a time whenever the FIFO is non-empty and transmission is enabled. Each word goes out on a single-wire asynchronous serial line: start bit, data LSB-first, parity bit, stop bit. It connects directly to the FIFO's `empty`, `ren` and registered `dout`, and drives the serial output pin.

---
 rtl/fifo_serial_tx.sv | 157 +++++++++++++++
 tb/tb_fifo_serial_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_serial_tx.sv
// Drains a synchronous FIFO one word at a time onto an asynchronous serial line:
// start bit, data LSB first, parity bit, stop bit. All outputs are registered.
module fifo_serial_tx #(
  parameter int DW           = 5,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          enable,
  input  logic          empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          ren,
  output logic          txd,
  output logic          busy,
  output logic          frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_next;
  logic [IW-1:0] bit_idx;
  logic [IW-1:0] bit_idx_next;
  logic [DW-1:0] shift;
  logic [DW-1:0] shift_next;
  logic          parity;
  logic          parity_next;
  logic          txd_next;
  logic          ren_next;
  logic          busy_next;
  logic          frame_done_next;
  logic          bit_end;
  logic [BW-1:0] baud_step;

  assign bit_end   = (baud == BAUD_LAST);
  assign baud_step = bit_end ? '0 : (baud + BW'(1));

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The baud counter only runs while a bit is on the line; every other state holds it at zero
  // so START always begins a fresh bit period.
  always_comb begin
    state_next   = state;
    baud_next    = '0;
    bit_idx_next = '0;
    shift_next   = shift;
    parity_next  = parity;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        shift_next  = fifo_dout;
        parity_next = (^fifo_dout) ^ PARITY_ODD;
        state_next  = START;
      end
      START: begin
        baud_next = baud_step;
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        baud_next    = baud_step;
        bit_idx_next = bit_idx;
        if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
            state_next = PARITY;
          end else begin
            bit_idx_next = bit_idx + IW'(1);
            shift_next   = shift >> 1;
          end
        end
      end
      PARITY: begin
        baud_next = baud_step;
        if (bit_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        baud_next = baud_step;
        if (bit_end) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so that each registered output lines up
  // exactly with the state it belongs to.
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PARITY:  txd_next = parity_next;
      default: txd_next = 1'b1;
    endcase
    ren_next        = (state_next == FETCH);
    busy_next       = (state_next != IDLE);
    frame_done_next = (state_next == STOP) && (baud_next == BAUD_LAST);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      txd        <= 1'b1;
      ren        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      baud       <= baud_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      parity     <= parity_next;
      txd        <= txd_next;
      ren        <= ren_next;
      busy       <= busy_next;
      frame_done <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-based FIFO, a waveform-list reference model checked every
// cycle, directed literal checks, and a second instance for the one-clock-per-bit odd-parity corner.
module tb_fifo_serial_tx;

  localparam int DW   = 5;
  localparam int CPB  = 4;
  localparam bit PODD = 1'b0;
  localparam int NREC = 100;

  typedef struct packed {
    logic ren;
    logic txd;
    logic busy;
    logic fd;
  } exp_t;

  localparam exp_t IDLE_EXP = 4'b0100;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          ren, txd, busy, frame_done;

  logic          rst_c = 1'b1;
  logic          enable_c = 1'b0;
  logic          empty_c = 1'b1;
  logic [DW-1:0] dout_c = '0;
  logic          ren_c, txd_c, busy_c, fd_c;

  fifo_serial_tx #(.DW(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .clock(clock), .rst(rst), .enable(enable), .empty(empty), .fifo_dout(fifo_dout),
    .ren(ren), .txd(txd), .busy(busy), .frame_done(frame_done)
  );

  fifo_serial_tx #(.DW(DW), .CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) dut_c (
    .clock(clock), .rst(rst_c), .enable(enable_c), .empty(empty_c), .fifo_dout(dout_c),
    .ren(ren_c), .txd(txd_c), .busy(busy_c), .frame_done(fd_c)
  );

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // FIFO with registered read data; the data bus is scrambled once the word has been consumed.
  logic [DW-1:0] fifo_q[$];
  int hold = 0;

  always @(negedge clock) begin
    if (ren === 1'b1) begin
      if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      hold = 2;
    end else if (hold > 0) begin
      hold--;
    end else begin
      fifo_dout = DW'($urandom);
    end
    empty = (fifo_q.size() == 0);
  end

  // Reference model: a launch expands the word into the full list of per-cycle outputs.
  exp_t exp_q[$];
  exp_t exp_cur = IDLE_EXP;
  bit   model_valid = 1'b0;

  task automatic modelLaunch(input logic [DW-1:0] w);
    logic [DW+2:0] bits;
    bits = {1'b1, (^w) ^ PODD, w, 1'b0};
    exp_q.push_back(exp_t'(4'b1110));
    exp_q.push_back(exp_t'(4'b0110));
    for (int b = 0; b < DW + 3; b++) begin
      for (int c = 0; c < CPB; c++) begin
        exp_q.push_back(exp_t'({1'b0, bits[b], 1'b1, (b == DW + 2) && (c == CPB - 1)}));
      end
    end
    exp_q.push_back(IDLE_EXP);
  endtask

  always @(posedge clock) begin
    if (rst === 1'b1) begin
      exp_q.delete();
      exp_cur = IDLE_EXP;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (exp_q.size() == 0 && enable && !empty) modelLaunch(fifo_q[0]);
      exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_EXP;
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      checkOutput("model_ren", ren, exp_cur.ren);
      checkOutput("model_txd", txd, exp_cur.txd);
      checkOutput("model_busy", busy, exp_cur.busy);
      checkOutput("model_frame_done", frame_done, exp_cur.fd);
    end
  end

  task automatic applyStimulus(input logic en, input logic r);
    @(negedge clock);
    enable = en;
    rst = r;
  endtask

  task automatic waitRen(input int budget, input string tag, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock);
      if (ren === 1'b1) found = 1'b1;
    end
    checkOutput({tag, "_ren_seen"}, found, 1);
  endtask

  // Called on the sample where ren is high; walks LOAD and then the whole frame bit by bit.
  task automatic checkFrameLiteral(input string tag, input logic [7:0] bits);
    int extra_ren;
    extra_ren = 0;
    @(negedge clock);
    checkOutput({tag, "_load_txd"}, txd, 1);
    for (int k = 0; k < 8 * CPB; k++) begin
      @(negedge clock);
      if (ren) extra_ren++;
      checkOutput({tag, "_txd"}, txd, bits[k / CPB]);
      checkOutput({tag, "_frame_done"}, frame_done, (k == 8 * CPB - 1));
    end
    @(negedge clock);
    checkOutput({tag, "_busy_after"}, busy, 0);
    checkOutput({tag, "_ren_total"}, 1 + extra_ren, 1);
  endtask

  logic rtxd[NREC];
  logic rren[NREC];
  logic rfd[NREC];

  initial begin
    bit found;
    int bad, nren, nfd, r1, r2, f1;
    bit idx_ok;
    logic [7:0] seq_c;

    applyStimulus(1'b0, 1'b1);
    @(negedge clock);
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_ren", ren, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    applyStimulus(1'b0, 1'b0);
    rst_c = 1'b0;

    $display("[TB] single word 10110");
    fifo_q.push_back(5'b10110);
    applyStimulus(1'b1, 1'b0);
    waitRen(10, "single", found);
    if (found) checkFrameLiteral("single", 8'b1110_1100);

    $display("[TB] empty and disabled idle");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (ren !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkOutput("empty_idle_bad_cycles", bad, 0);
    applyStimulus(1'b0, 1'b0);
    fifo_q.push_back(5'b00001);
    fifo_q.push_back(5'b11111);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (ren !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkOutput("disabled_idle_bad_cycles", bad, 0);

    $display("[TB] back-to-back 00001, 11111");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < NREC; i++) begin
      @(negedge clock);
      rtxd[i] = txd;
      rren[i] = ren;
      rfd[i] = frame_done;
    end
    nren = 0; r1 = -1; r2 = -1; f1 = -1;
    for (int i = 0; i < NREC; i++) begin
      if (rren[i]) begin
        nren++;
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      if (rfd[i] && f1 < 0) f1 = i;
    end
    checkOutput("b2b_ren_count", nren, 2);
    idx_ok = (r1 >= 0) && (r2 >= 0) && (f1 >= CPB) && (r2 + 27 < NREC);
    checkOutput("b2b_indices_valid", idx_ok, 1);
    if (idx_ok) begin
      checkOutput("b2b_ren_spacing", r2 - r1, 35);
      checkOutput("b2b_parity_first", rtxd[r1 + 2 + 6 * CPB + 1], 1);
      checkOutput("b2b_parity_second", rtxd[r2 + 2 + 6 * CPB + 1], 1);
      checkOutput("b2b_high_gap", (r2 + 2) - (f1 - CPB + 1), 7);
    end

    $display("[TB] enable drop mid-frame");
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) fifo_q.push_back(DW'($urandom));
    waitRen(10, "drop", found);
    repeat (12) @(negedge clock);
    applyStimulus(1'b0, 1'b0);
    nren = 0; nfd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (ren) nren++;
      if (frame_done) nfd++;
    end
    checkOutput("drop_new_ren", nren, 0);
    checkOutput("drop_frame_completed", nfd, 1);

    $display("[TB] reset during parity");
    applyStimulus(1'b1, 1'b0);
    waitRen(10, "rstmid", found);
    repeat (27) @(negedge clock);
    applyStimulus(1'b1, 1'b1);
    @(negedge clock);
    checkOutput("rstmid_txd", txd, 1);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_frame_done", frame_done, 0);
    rst = 1'b0;
    waitRen(20, "rstmid_relaunch", found);
    repeat (40) @(negedge clock);

    $display("[TB] corner: one clock per bit, odd parity, word 00000");
    seq_c = 8'b1100_0000;
    @(negedge clock);
    dout_c = 5'b00000;
    empty_c = 1'b0;
    enable_c = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (ren_c === 1'b1) found = 1'b1;
    end
    checkOutput("corner_ren_seen", found, 1);
    empty_c = 1'b1;
    enable_c = 1'b0;
    @(negedge clock);
    checkOutput("corner_load_txd", txd_c, 1);
    checkOutput("corner_load_busy", busy_c, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k == 0) dout_c = 5'b11111;
      checkOutput("corner_txd", txd_c, seq_c[k]);
      checkOutput("corner_frame_done", fd_c, (k == 7));
    end
    @(negedge clock);
    checkOutput("corner_busy_after", busy_c, 0);
    checkOutput("corner_txd_after", txd_c, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 4) != 0), ($urandom_range(0, 399) == 0));
      if ($urandom_range(0, 19) == 0 && fifo_q.size() < 8) fifo_q.push_back(DW'($urandom));
    end
    applyStimulus(1'b0, 1'b0);
    repeat (60) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
